// File: rtl/vga_sync_monitor_if.sv
// VGA line bundle: the sync strobes and colour bus as driven by a timing generator.
// The generator owns the master side; monitors attach as slaves.
interface vga_sync_monitor_if;
  logic       HS;
  logic       VS;
  logic [2:0] RED;
  logic [2:0] GREEN;
  logic [1:0] BLUE;

  modport master (output HS, VS, RED, GREEN, BLUE);
  modport slave  (input  HS, VS, RED, GREEN, BLUE);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from HS/VS,
// checks sync placement, reports lock/errors and captures one probe pixel.
module vga_sync_monitor #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 29,
  parameter int PROBE_X   = 320,
  parameter int PROBE_Y   = 240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  vga_sync_monitor_if.slave    vga,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic                 active,
  output logic                 locked,
  output logic                 h_err,
  output logic                 v_err,
  output logic                 frame_done,
  output logic [7:0]           probe_rgb,
  output logic                 probe_valid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_POS  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] VS_POS  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] PRB_X   = 10'(PROBE_X);
  localparam logic [9:0] PRB_Y   = 10'(PROBE_Y);

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGN,
    V_ALIGN,
    LOCKED
  } state_t;

  state_t     state_reg, state_next;
  logic       vs_seen_reg, vs_seen_next;
  logic       hs_prev_reg, vs_prev_reg;
  logic [9:0] hcount_reg, vcount_reg;
  logic [9:0] hcount_next, vcount_next;
  logic [9:0] h_inc, v_inc;
  logic       h_wrap, h_chk, v_chk;
  logic       hs_fall, vs_fall, h_mis, v_mis;
  logic       active_next, probe_hit;

  // The counters always hold the coordinate of the most recently sampled pixel.
  assign x = hcount_reg;
  assign y = vcount_reg;

  always_comb begin
    hs_fall = hs_prev_reg & ~vga.HS;
    vs_fall = vs_prev_reg & ~vga.VS;
    h_wrap  = (hcount_reg == H_LAST);
    h_inc   = h_wrap ? '0 : hcount_reg + 10'd1;
    v_inc   = h_wrap ? ((vcount_reg == V_LAST) ? '0 : vcount_reg + 10'd1) : vcount_reg;

    // A checkpoint is missed either by an edge in the wrong place or by no edge at all.
    h_chk = (h_inc == HS_POS);
    v_chk = (h_inc == '0) && (v_inc == VS_POS);
    h_mis = hs_fall ? ~h_chk : h_chk;
    v_mis = vs_fall ? ~v_chk : v_chk;

    hcount_next = hs_fall ? HS_POS : h_inc;
    vcount_next = vs_fall ? VS_POS : v_inc;

    state_next   = state_reg;
    vs_seen_next = vs_seen_reg;
    case (state_reg)
      SEARCH: begin
        if (hs_fall) state_next = H_ALIGN;
      end
      H_ALIGN: begin
        if (hs_fall && !h_mis) state_next = V_ALIGN;
      end
      V_ALIGN: begin
        if (h_mis) begin
          state_next   = H_ALIGN;
          vs_seen_next = 1'b0;
        end else if (vs_fall && !vs_seen_reg) begin
          vs_seen_next = 1'b1;
        end else if (vs_seen_reg && vs_fall && !v_mis) begin
          state_next   = LOCKED;
          vs_seen_next = 1'b0;
        end else if (vs_seen_reg && v_mis) begin
          vs_seen_next = 1'b0;
        end
      end
      LOCKED: begin
        if (h_mis) begin
          state_next   = H_ALIGN;
          vs_seen_next = 1'b0;
        end else if (v_mis) begin
          state_next   = V_ALIGN;
          vs_seen_next = 1'b0;
        end
      end
      default: begin
        state_next   = SEARCH;
        vs_seen_next = 1'b0;
      end
    endcase

    active_next = (state_next == LOCKED) && (hcount_next < H_VIS) && (vcount_next < V_VIS);
    probe_hit   = active_next && (hcount_next == PRB_X) && (vcount_next == PRB_Y);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= SEARCH;
      vs_seen_reg <= 1'b0;
      hs_prev_reg <= 1'b1;
      vs_prev_reg <= 1'b1;
      hcount_reg  <= '0;
      vcount_reg  <= '0;
      active      <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_done  <= 1'b0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else if (pix_en) begin
      state_reg   <= state_next;
      vs_seen_reg <= vs_seen_next;
      hs_prev_reg <= vga.HS;
      vs_prev_reg <= vga.VS;
      hcount_reg  <= hcount_next;
      vcount_reg  <= vcount_next;
      active      <= active_next;
      locked      <= (state_next == LOCKED);
      h_err       <= (state_reg == LOCKED) && h_mis;
      v_err       <= (state_reg == LOCKED) && v_mis;
      frame_done  <= (state_reg == LOCKED) && !h_mis && !v_mis &&
                     (hcount_next == '0) && (vcount_next == '0);
      if (probe_hit) begin
        probe_rgb   <= {vga.RED, vga.GREEN, vga.BLUE};
        probe_valid <= 1'b1;
      end else if (state_next != LOCKED) begin
        probe_valid <= 1'b0;
      end
    end else begin
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
